// File: rtl/pc_sequencer_if.sv
// Purpose: fetch-control bundle between the PC sequencer and its pipeline/imem environment.
// Ports:   master = environment (drives redirects, stall, imem_ready, boot vector);
//          slave  = pc_sequencer (drives PC, hold, imem_req, fetch_valid, flush).
// Optional: EXCEPTION_VECTOR_EN adds exc_req (master->slave) and epc (slave->master).
interface pc_sequencer_if;
  logic [31:0] pc_initial;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        stall_req;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_next;
  logic        pc_hold;
  logic        imem_req;
  logic        fetch_valid;
  logic        flush;
`ifdef EXCEPTION_VECTOR_EN
  logic        exc_req;
  logic [31:0] epc;
`endif

  modport master (
    output pc_initial, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, stall_req, imem_ready,
`ifdef EXCEPTION_VECTOR_EN
    output exc_req,
    input  epc,
`endif
    input  pc_out, pc_next, pc_hold, imem_req, fetch_valid, flush
  );

  modport slave (
    input  pc_initial, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, stall_req, imem_ready,
`ifdef EXCEPTION_VECTOR_EN
    input  exc_req,
    output epc,
`endif
    output pc_out, pc_next, pc_hold, imem_req, fetch_valid, flush
  );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: program-counter sequencer: BOOT/FETCH/MISS control, redirect priority
//          (jr > jump > branch > pc+4), pending redirect across imem misses.
// Latency: outputs are combinational from state and inputs; PC loads on the edge
//          after a completed fetch with pc_hold=0.
// Backpressure: imem_ready=0 holds the PC (MISS); stall_req holds unless a redirect is present.
// Ports: clk, rst_n (async active-low), bus (pc_sequencer_if.slave).
// Optional: EXCEPTION_VECTOR_EN adds exc_req/epc; exception outranks all redirects.
module pc_sequencer (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, MISS = 2'd2} state_t;

`ifdef EXCEPTION_VECTOR_EN
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        active;
  logic        complete;
  logic        redir_now;
  logic [31:0] redir_raw;
  logic [31:0] redir_tgt;
  logic        redir_any;
  logic [31:0] load_tgt;
  logic [31:0] pc_cur;
  logic [31:0] pc_seq;

  logic [31:0] pc_next_o;
  logic        pc_hold_o;
  logic        imem_req_o;
  logic        fetch_valid_o;
  logic        flush_o;

  // Redirect select: later assignments override earlier ones, giving the priority order.
  always_comb begin
    redir_now = 1'b0;
    redir_raw = 32'h0;
    if (bus.branch_taken) begin
      redir_now = 1'b1;
      redir_raw = bus.branch_target;
    end
    if (bus.jump) begin
      redir_now = 1'b1;
      redir_raw = bus.jump_target;
    end
    if (bus.jr) begin
      redir_now = 1'b1;
      redir_raw = bus.jr_target;
    end
`ifdef EXCEPTION_VECTOR_EN
    if (bus.exc_req) begin
      redir_now = 1'b1;
      redir_raw = EXC_VECTOR;
    end
`endif
  end

  assign redir_tgt = {redir_raw[31:2], 2'b00};
  assign active    = (state_q != BOOT);
  assign complete  = active && bus.imem_ready;
  // A pending target counts as a live redirect: it must load at the next completed fetch.
  assign redir_any = redir_now || pend_q;
  assign load_tgt  = redir_now ? redir_tgt : pend_tgt_q;
  // In BOOT (including while reset is held) the boot vector is presented directly,
  // so pc_out tracks pc_initial asynchronously without loading data on reset.
  assign pc_cur    = (state_q == BOOT) ? bus.pc_initial : pc_q;
  assign pc_seq    = pc_cur + 32'd4;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = bus.imem_ready ? FETCH : MISS;
      MISS:    state_d = bus.imem_ready ? FETCH : MISS;
      default: state_d = BOOT;
    endcase
  end

  // Output logic.
  always_comb begin
    pc_next_o     = bus.pc_initial;
    pc_hold_o     = 1'b1;
    imem_req_o    = 1'b0;
    fetch_valid_o = 1'b0;
    flush_o       = 1'b0;
    if (active) begin
      imem_req_o = 1'b1;
      pc_next_o  = redir_any ? load_tgt : pc_seq;
      flush_o    = redir_now;
      if (complete) begin
        // A completing fetch under a redirect is wrong-path: discard it but load the target.
        if (redir_any) begin
          pc_hold_o = 1'b0;
        end else if (!bus.stall_req) begin
          pc_hold_o     = 1'b0;
          fetch_valid_o = 1'b1;
        end
      end
    end
  end

  // Pending redirect: captured only while the fetch is still outstanding.
  always_comb begin
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (!active || complete) begin
      pend_d = 1'b0;
    end else if (redir_now) begin
      pend_d     = 1'b1;
      pend_tgt_d = redir_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= 32'h0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      if (state_q == BOOT) begin
        pc_q <= bus.pc_initial;
      end else if (!pc_hold_o) begin
        pc_q <= pc_next_o;
      end
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef EXCEPTION_VECTOR_EN
  logic [31:0] epc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q <= 32'h0;
    end else if (active && bus.exc_req) begin
      epc_q <= pc_cur;
    end
  end

  assign bus.epc = epc_q;
`endif

  assign bus.pc_out      = pc_cur;
  assign bus.pc_next     = pc_next_o;
  assign bus.pc_hold     = pc_hold_o;
  assign bus.imem_req    = imem_req_o;
  assign bus.fetch_valid = fetch_valid_o;
  assign bus.flush       = flush_o;

endmodule
